// File: rtl/rob_alloc_commit_ctrl_if.sv
// Bundle between the ROB sequencer and the issue stage / entry array.
// ROB_DUAL_COMMIT_EN adds the second retire port (commit1_*).
interface rob_if #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = 3,
   parameter int DEST_W  = 5
);
   logic                      alloc_req;
   logic                      alloc_gnt;
   logic [IDX_W-1:0]          alloc_idx;
   logic [ENTRIES-1:0]        sel;
   logic [ENTRIES-1:0]        entry_done;
   logic [ENTRIES*DEST_W-1:0] entry_dest;
   logic [IDX_W-1:0]          head;
   logic                      commit_valid;
   logic [IDX_W-1:0]          commit_idx;
   logic [DEST_W-1:0]         commit_dest;
   logic                      flush;
   logic                      entry_clr;
   logic                      full;
   logic                      empty;
   logic [IDX_W:0]            count;
`ifdef ROB_DUAL_COMMIT_EN
   logic                      commit1_valid;
   logic [IDX_W-1:0]          commit1_idx;
   logic [DEST_W-1:0]         commit1_dest;

   modport master (
      output alloc_req, entry_done, entry_dest, flush,
      input  alloc_gnt, alloc_idx, sel, head, commit_valid, commit_idx,
             commit_dest, entry_clr, full, empty, count,
             commit1_valid, commit1_idx, commit1_dest
   );
   modport slave (
      input  alloc_req, entry_done, entry_dest, flush,
      output alloc_gnt, alloc_idx, sel, head, commit_valid, commit_idx,
             commit_dest, entry_clr, full, empty, count,
             commit1_valid, commit1_idx, commit1_dest
   );
`else
   modport master (
      output alloc_req, entry_done, entry_dest, flush,
      input  alloc_gnt, alloc_idx, sel, head, commit_valid, commit_idx,
             commit_dest, entry_clr, full, empty, count
   );
   modport slave (
      input  alloc_req, entry_done, entry_dest, flush,
      output alloc_gnt, alloc_idx, sel, head, commit_valid, commit_idx,
             commit_dest, entry_clr, full, empty, count
   );
`endif
endinterface

// File: rtl/rob_alloc_commit_ctrl.sv
// ROB sequencer: head/tail/occupancy, in-order commit and multi-cycle flush.
// Optional macro ROB_DUAL_COMMIT_EN retires head and head+1 in one cycle.
module rob_alloc_commit_ctrl #(
   parameter int ENTRIES      = 8,
   parameter int IDX_W        = 3,
   parameter int DEST_W       = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   rob_if.slave bus
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   localparam logic [3:0]     FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [IDX_W:0] CNT_FULL    = (IDX_W+1)'(ENTRIES);

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [IDX_W:0]     r_count, w_count_nxt;
   logic [3:0]         r_fcnt, w_fcnt_nxt;
   logic               w_run, w_full, w_empty, w_gnt, w_cv0, w_cv1, w_clr;
   logic [IDX_W:0]     w_nret;
   logic [DEST_W-1:0]  w_dest [ENTRIES];

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         w_dest[i] = bus.entry_dest[i*DEST_W +: DEST_W];
      end
   end

   // Grant/commit decisions use the current count, never the post-edge one.
   assign w_run   = (r_state == ST_RUN);
   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);
   assign w_gnt   = bus.alloc_req & ~w_full & ~bus.flush & w_run;
   assign w_cv0   = bus.entry_done[r_head] & ~w_empty & ~bus.flush & w_run;

`ifdef ROB_DUAL_COMMIT_EN
   logic [IDX_W-1:0] w_head1;
   assign w_head1           = r_head + IDX_W'(1);
   assign w_cv1             = w_cv0 & bus.entry_done[w_head1] &
                              (r_count >= (IDX_W+1)'(2));
   assign bus.commit1_valid = w_cv1;
   assign bus.commit1_idx   = w_head1;
   assign bus.commit1_dest  = w_dest[w_head1];
`else
   assign w_cv1 = 1'b0;
`endif

   assign w_nret = (IDX_W+1)'(w_cv0) + (IDX_W+1)'(w_cv1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_clr       = 1'b0;
      w_head_nxt  = r_head + w_nret[IDX_W-1:0];
      w_tail_nxt  = r_tail + IDX_W'(w_gnt);
      w_count_nxt = r_count + (IDX_W+1)'(w_gnt) - w_nret;
      unique case (r_state)
         ST_RUN: begin
            if (bus.flush) begin
               w_state_nxt = ST_FLUSH;
               w_fcnt_nxt  = FCNT_RELOAD;
               w_head_nxt  = '0;
               w_tail_nxt  = '0;
               w_count_nxt = '0;
            end
         end
         ST_FLUSH: begin
            w_clr       = 1'b1;
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
            // A repeated flush extends the clear window from the top.
            if (bus.flush) begin
               w_fcnt_nxt = FCNT_RELOAD;
            end else if (r_fcnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_fcnt_nxt = r_fcnt - 4'd1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign bus.alloc_gnt    = w_gnt;
   assign bus.alloc_idx    = r_tail;
   assign bus.sel          = w_gnt ? (ENTRIES'(1) << r_tail) : '0;
   assign bus.head         = r_head;
   assign bus.commit_valid = w_cv0;
   assign bus.commit_idx   = r_head;
   assign bus.commit_dest  = w_dest[r_head];
   assign bus.entry_clr    = w_clr;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.count        = r_count;

endmodule

// File: tb/tb_rob_alloc_commit_ctrl.sv
// Randomized + directed bench for rob_alloc_commit_ctrl with a queue-based
// occupancy model and a scoreboard monitor sampling on the falling edge.
module tb_rob_alloc_commit_ctrl;
   localparam int ENTRIES      = 8;
   localparam int IDX_W        = 3;
   localparam int DEST_W       = 5;
   localparam int FLUSH_CYCLES = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rob_if #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .DEST_W(DEST_W)) bus ();

   rob_alloc_commit_ctrl #(
      .ENTRIES(ENTRIES), .IDX_W(IDX_W), .DEST_W(DEST_W),
      .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic                gnt;
      logic [ENTRIES-1:0]  sel;
      logic [IDX_W-1:0]    aidx;
      logic [IDX_W-1:0]    hd;
      logic                cv;
      logic [DEST_W-1:0]   cdest;
      logic                clr;
      logic [IDX_W:0]      cnt;
      logic                full;
      logic                empty;
      logic                c1v;
      logic [DEST_W-1:0]   c1dest;
   } exp_t;

   exp_t sb[$];

   // Reference model: ROB as occupancy + wrapping head/tail, flush as cycles left.
   int m_count = 0, m_head = 0, m_tail = 0, m_flush_left = 0;
   bit m_in_flush = 0;
   int n_checks = 0, n_errors = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(bit req, logic [ENTRIES-1:0] done, bit fl, bit rn, bit chk);
      exp_t e;
      int nret;
      logic [DEST_W-1:0] dest [ENTRIES];
      @(posedge clk);
      #1;
      for (int i = 0; i < ENTRIES; i++) begin
         dest[i] = DEST_W'($urandom);
         bus.entry_dest[i*DEST_W +: DEST_W] = dest[i];
      end
      bus.alloc_req  = req;
      bus.entry_done = done;
      bus.flush      = fl;
      rst_n          = rn;

      e.gnt    = req && (m_count < ENTRIES) && !fl && !m_in_flush;
      e.sel    = '0;
      if (e.gnt) e.sel[m_tail] = 1'b1;
      e.aidx   = IDX_W'(m_tail);
      e.hd     = IDX_W'(m_head);
      e.cv     = done[m_head] && (m_count > 0) && !fl && !m_in_flush;
      e.cdest  = dest[m_head];
      e.clr    = m_in_flush;
      e.cnt    = (IDX_W+1)'(m_count);
      e.full   = (m_count == ENTRIES);
      e.empty  = (m_count == 0);
`ifdef ROB_DUAL_COMMIT_EN
      e.c1v    = e.cv && done[(m_head + 1) % ENTRIES] && (m_count >= 2);
`else
      e.c1v    = 1'b0;
`endif
      e.c1dest = dest[(m_head + 1) % ENTRIES];
      nret     = int'(e.cv) + int'(e.c1v);
      if (chk) sb.push_back(e);

      if (!rn) begin
         m_count = 0; m_head = 0; m_tail = 0; m_flush_left = 0; m_in_flush = 0;
      end else if (m_in_flush) begin
         if (fl) m_flush_left = FLUSH_CYCLES;
         else    m_flush_left--;
         m_in_flush = (m_flush_left > 0);
      end else if (fl) begin
         m_in_flush = 1; m_flush_left = FLUSH_CYCLES;
         m_count = 0; m_head = 0; m_tail = 0;
      end else begin
         m_tail  = (m_tail + int'(e.gnt)) % ENTRIES;
         m_head  = (m_head + nret) % ENTRIES;
         m_count = m_count + int'(e.gnt) - nret;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("alloc_gnt", 32'(bus.alloc_gnt), 32'(e.gnt));
         check("sel",       32'(bus.sel),       32'(e.sel));
         check("alloc_idx", 32'(bus.alloc_idx), 32'(e.aidx));
         check("head",      32'(bus.head),      32'(e.hd));
         check("commit_valid", 32'(bus.commit_valid), 32'(e.cv));
         check("entry_clr", 32'(bus.entry_clr), 32'(e.clr));
         check("count",     32'(bus.count),     32'(e.cnt));
         check("full",      32'(bus.full),      32'(e.full));
         check("empty",     32'(bus.empty),     32'(e.empty));
         if (e.cv) begin
            check("commit_idx",  32'(bus.commit_idx),  32'(e.hd));
            check("commit_dest", 32'(bus.commit_dest), 32'(e.cdest));
         end
`ifdef ROB_DUAL_COMMIT_EN
         check("commit1_valid", 32'(bus.commit1_valid), 32'(e.c1v));
         if (e.c1v) check("commit1_dest", 32'(bus.commit1_dest), 32'(e.c1dest));
`endif
      end
   end

   initial begin
      int guard;
      bus.alloc_req  = 1'b0;
      bus.entry_done = '0;
      bus.entry_dest = '0;
      bus.flush      = 1'b0;
      rst_n          = 1'b0;

      step(0, '0, 0, 0, 0);
      step(0, 8'hFF, 0, 0, 1);
      // Fill all eight entries, then a ninth request is refused.
      for (int i = 0; i < 9; i++) step(1, '0, 0, 1, 1);
      // Commit at full with a pending request; then the freed slot is granted.
      step(1, 8'h01, 0, 1, 1);
      step(1, 8'h00, 0, 1, 1);
      // head=1 -> 2, then only non-head entry 3 is done.
      step(0, 8'h02, 0, 1, 1);
      step(0, 8'h08, 0, 1, 1);
      step(0, 8'h08, 0, 1, 1);
      step(0, 8'h0C, 0, 1, 1);
      step(0, 8'h08, 0, 1, 1);
      step(0, 8'h00, 0, 1, 1);
      while (m_count > 4) step(0, ENTRIES'(1) << m_head, 0, 1, 1);
      for (int i = 0; i < 20; i++) step(1, 8'hFF, 0, 1, 1);
      // Flush at count 5 with a pending request.
      while (m_count < 5) step(1, '0, 0, 1, 1);
      step(1, '0, 1, 1, 1);
      for (int i = 0; i < 3; i++) step(1, '0, 0, 1, 1);
      // Flush extended once, then reset aborts it.
      step(0, '0, 1, 1, 1);
      step(0, '0, 1, 1, 1);
      step(0, '0, 0, 0, 1);
      step(1, '0, 0, 1, 1);
      step(1, 8'hFF, 0, 1, 1);

      for (int i = 0; i < 2000; i++) begin
         step(bit'($urandom_range(0, 3) != 0), ENTRIES'($urandom),
              bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 199) != 0), 1);
      end
      step(0, '0, 0, 1, 1);

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rob_alloc_commit_ctrl.md
Name: rob_alloc_commit_ctrl

Overview:
Central sequencer for the reorder buffer (ROB) entry array.
- Owns head, tail and occupancy, and grants allocation of the tail entry to the instruction issue stage via a one-hot select.
- Commits completed entries strictly in program order from head.
- Performs a multi-cycle flush that clears every entry and resets the pointers.

Parameters:
- ENTRIES, 8, number of ROB entries; must be a power of 2, range 2..16.
- IDX_W, 3, log2(ENTRIES); width of head, tail and index buses.
- DEST_W, 5, architectural destination register index width.
- FLUSH_CYCLES, 2, number of cycles entry_clr is held during a flush; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alloc_req  in  1  issue stage requests an entry this cycle.
- alloc_gnt  out  1  request accepted this cycle (combinational).
- alloc_idx  out  IDX_W  index of the granted entry; equals tail.
- sel  out  ENTRIES  one-hot entry load select; bit tail set only when alloc_gnt=1.
- entry_done  in  ENTRIES  per-entry flag: result captured and ready to commit.
- entry_dest  in  ENTRIES*DEST_W  flattened destination fields; entry i occupies bits [i*DEST_W +: DEST_W].
- head  out  IDX_W  current commit pointer, broadcast to all entries.
- commit_valid  out  1  head entry retires this cycle (combinational).
- commit_idx  out  IDX_W  index of the retiring entry (= head).
- commit_dest  out  DEST_W  destination of the retiring entry.
- flush  in  1  discard all in-flight entries (mispredict or exception).
- entry_clr  out  1  clear pulse to all entries while flushing.
- full  out  1  count==ENTRIES.
- empty  out  1  count==0.
- count  out  IDX_W+1  current occupancy.

Behaviour:
- Registers: head, tail (IDX_W each), count (IDX_W+1), state, flush counter fcnt (4 bits).
- Reset (rst_n=0 at a clock edge): state=RUN, head=0, tail=0, count=0, fcnt=0.
  - Resulting outputs: empty=1, full=0, alloc_gnt=0, commit_valid=0, entry_clr=0, sel=0.
  - A reset asserted mid-flush aborts the flush immediately.
- FSM state RUN, normal operation:
  - alloc_gnt = alloc_req & ~full & ~flush & (state==RUN).
  - commit_valid = entry_done[head] & ~empty & ~flush & (state==RUN).
  - commit_dest = entry_dest slice indexed by head, driven every cycle; meaningful only when commit_valid=1.
  - On the edge: tail += alloc_gnt; head += commit_valid.
  - count += alloc_gnt − commit_valid.
  - A simultaneous alloc and commit leaves count unchanged.
- Full/empty grant rules use the current cycle's count, not the next:
  - At full, no grant is given even if a commit occurs in the same cycle.
  - At empty, commit_valid=0 regardless of entry_done.
- Pointers wrap modulo ENTRIES (natural IDX_W overflow), e.g. tail 7 → 0 for ENTRIES=8.
- Latency:
  - Grant and sel are same-cycle; the entry loads on that edge.
  - The head increment is visible one cycle after commit_valid.
  - Entries compare head to their index one cycle before their own write enable.
- flush=1 in RUN:
  - Same cycle: alloc_gnt=0, commit_valid=0.
  - Next state FLUSH, with fcnt=FLUSH_CYCLES−1.
- FSM state FLUSH:
  - entry_clr=1 and alloc_gnt=0 throughout.
  - head, tail, count are forced to 0 on entry into FLUSH.
  - fcnt decrements each cycle; FLUSH→RUN when fcnt==0.
  - flush asserted again during FLUSH reloads fcnt (flush is extended).
  - entry_done is ignored throughout.
- Only one commit per cycle; commit order is strictly head order, and entry_done of non-head entries has no effect.

Optional Feature:
- Macro ROB_DUAL_COMMIT_EN.
- Defined:
  - Adds ports commit1_valid (out 1), commit1_idx (out IDX_W), commit1_dest (out DEST_W).
  - commit1_valid = commit_valid & entry_done[head+1] & (count≥2).
  - head and count advance by commit_valid+commit1_valid; entry head+1 retires in the same cycle as head.
  - Entries are told of the dual retire through head.
- Undefined: the extra ports are absent; single-commit behaviour exactly as above.

Test Plan:
- Reset then 8 alloc_req cycles (ENTRIES=8): sel walks 0x01..0x80, and count reaches 8 one cycle after the 8th grant (full=1 in the cycle after the 8th grant). A 9th req gets alloc_gnt=0 and tail stays 0.
- Full ROB, set entry_done[0] with alloc_req=1 in the same cycle: commit_valid=1, commit_dest=entry 0 dest, alloc_gnt=0. Next cycle: head=1, count=7, then alloc_gnt=1 with sel=0x01.
- entry_done[3]=1 while head=2 and entry_done[2]=0: commit_valid=0, head holds at 2. Raising entry_done[2] commits idx 2 then idx 3 on consecutive cycles.
- Wrap-around: 20 cycles of steady alloc+commit at count=4: count stays 4 and head/tail sequences wrap 7→0 correctly.
- Flush at count=5 with alloc_req=1: same-cycle alloc_gnt=0. Then entry_clr=1 for exactly 2 cycles; afterwards head=tail=count=0, empty=1, and alloc resumes with sel=0x01.
- rst_n low during the FLUSH state: next cycle entry_clr=0, state RUN, all pointers 0.
